// File: rtl/emb_index_fetcher.sv
// Embedding lookup request path: index stream -> table read -> row FIFO.
// Optional EMB_FETCH_PAD_ZERO_EN: index 0 returns a zero row without a read.
module emb_index_fetcher #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 10,
  parameter int TABLE_DEPTH = 1024,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    idx_valid,
  output logic                    idx_ready,
  input  logic [INDEX_WIDTH-1:0]  idx,
  input  logic                    idx_last,
  output logic                    tbl_read_enable,
  output logic [INDEX_WIDTH-1:0]  tbl_index,
  input  logic [DATA_WIDTH*8-1:0] tbl_data,
  output logic                    vec_valid,
  input  logic                    vec_ready,
  output logic [DATA_WIDTH*8-1:0] vec_data,
  output logic                    vec_last,
  output logic                    busy,
  output logic                    err_oob
);

  localparam int VW = DATA_WIDTH * 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [INDEX_WIDTH:0] TD =
    (INDEX_WIDTH+1)'(TABLE_DEPTH);

  typedef struct packed {
    logic valid;
    logic last;
    logic zero;
  } tag_t;

  tag_t                   rd_q;
  logic [INDEX_WIDTH-1:0] rd_index;
  tag_t                   cp_q;

  logic [VW:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW:0]   credits;

  logic accept;
  logic is_oob;
  logic is_pad;
  logic push;
  logic pop;

  assign is_oob = {1'b0, idx} >= TD;

`ifdef EMB_FETCH_PAD_ZERO_EN
  assign is_pad = (idx == '0);
`else
  assign is_pad = 1'b0;
`endif

  // In-flight rows hold a reserved slot, so a push never finds the FIFO full.
  assign credits = {1'b0, count}
                 + {{CW{1'b0}}, rd_q.valid}
                 + {{CW{1'b0}}, cp_q.valid};

  assign idx_ready = rst_n
                   && (credits < (CW+1)'(FIFO_DEPTH));
  assign accept    = idx_valid && idx_ready;

  assign tbl_read_enable = rd_q.valid && !rd_q.zero;
  assign tbl_index = tbl_read_enable ? rd_index : '0;

  assign push      = cp_q.valid;
  assign vec_valid = (count != '0);
  assign pop       = vec_valid && vec_ready;
  assign vec_data  = vec_valid ? mem[rptr][VW-1:0] : '0;
  assign vec_last  = vec_valid && mem[rptr][VW];

  assign busy = rd_q.valid || cp_q.valid || vec_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      rd_index <= '0;
      cp_q     <= '0;
      err_oob  <= 1'b0;
    end else begin
      rd_q.valid <= accept;
      if (accept) begin
        rd_index  <= idx;
        rd_q.last <= idx_last;
        rd_q.zero <= is_oob || is_pad;
      end
      cp_q <= rd_q;
      if (accept && is_oob)
        err_oob <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= {cp_q.last, cp_q.zero ? {VW{1'b0}} : tbl_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_emb_index_fetcher.sv
// Directed bench for emb_index_fetcher with a registered table model.
// Table depth is set to 512 so the out-of-bounds path is reachable.
module tb_emb_index_fetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        idx_valid;
  logic        idx_ready;
  logic [9:0]  idx;
  logic        idx_last;
  logic        tbl_read_enable;
  logic [9:0]  tbl_index;
  logic [63:0] tbl_data = '0;
  logic        vec_valid;
  logic        vec_ready;
  logic [63:0] vec_data;
  logic        vec_last;
  logic        busy;
  logic        err_oob;

  int checks   = 0;
  int failures = 0;
  int oob_reads = 0;
  logic [64:0] rxq [$];

  always #5 clk = ~clk;

  emb_index_fetcher #(
    .DATA_WIDTH(8),
    .INDEX_WIDTH(10),
    .TABLE_DEPTH(512),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .idx_valid(idx_valid),
    .idx_ready(idx_ready),
    .idx(idx),
    .idx_last(idx_last),
    .tbl_read_enable(tbl_read_enable),
    .tbl_index(tbl_index),
    .tbl_data(tbl_data),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .vec_data(vec_data),
    .vec_last(vec_last),
    .busy(busy),
    .err_oob(err_oob)
  );

  // Row i lane j = j + 8*(i-5); row 5 is 0x0706050403020100.
  function automatic logic [63:0] row(int i);
    logic [63:0] r;
    for (int j = 0; j < 8; j++)
      r[j*8 +: 8] = 8'(j + 8 * (i - 5));
    return r;
  endfunction

  always @(posedge clk) begin
    tbl_data <= tbl_read_enable ? row(int'(tbl_index)) : '0;
    if (tbl_read_enable && tbl_index >= 10'd512)
      oob_reads++;
  end

  always @(negedge clk)
    if (rst_n && vec_valid && vec_ready)
      rxq.push_back({vec_last, vec_data});

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int i, logic last);
    idx_valid = 1'b1;
    idx       = 10'(i);
    idx_last  = last;
    chk("send_rdy", 64'(idx_ready), 64'd1);
    tick();
    idx_valid = 1'b0;
    idx_last  = 1'b0;
  endtask

  initial begin
    int n;
    logic acc;
    rst_n     = 1'b0;
    idx_valid = 1'b0;
    idx       = '0;
    idx_last  = 1'b0;
    vec_ready = 1'b0;
    tick();
    chk("rst_ready", 64'(idx_ready), 64'd0);
    chk("rst_vvalid", 64'(vec_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rden", 64'(tbl_read_enable), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(idx_ready), 64'd1);

    // single lookup
    send(5, 1'b0);
    chk("single_rden", 64'(tbl_read_enable), 64'd1);
    chk("single_tidx", 64'(tbl_index), 64'd5);
    chk("single_v0", 64'(vec_valid), 64'd0);
    tick();
    chk("single_rden_off", 64'(tbl_read_enable), 64'd0);
    chk("single_v1", 64'(vec_valid), 64'd0);
    tick();
    chk("single_v2", 64'(vec_valid), 64'd1);
    chk("single_data", vec_data, 64'h0706050403020100);
    chk("single_last", 64'(vec_last), 64'd0);
    chk("single_busy", 64'(busy), 64'd1);
    vec_ready = 1'b1;
    tick();
    chk("single_popped", 64'(vec_valid), 64'd0);
    chk("single_idle", 64'(busy), 64'd0);
    rxq.delete();

    // streaming
    for (int i = 1; i <= 16; i++) begin
      idx_valid = 1'b1;
      idx       = 10'(i);
      idx_last  = (i == 16);
      chk("stream_rdy", 64'(idx_ready), 64'd1);
      tick();
    end
    idx_valid = 1'b0;
    idx_last  = 1'b0;
    repeat (5) tick();
    chk("stream_count", 64'(rxq.size()), 64'd16);
    for (int k = 0; k < 16; k++)
      if (k < rxq.size()) begin
        chk("stream_data", rxq[k][63:0], row(k + 1));
        chk("stream_last", 64'(rxq[k][64]), 64'(k == 15));
      end
    rxq.delete();

    // backpressure
    vec_ready = 1'b0;
    n = 0;
    idx_valid = 1'b1;
    idx = 10'd20;
    for (int c = 0; c < 10; c++) begin
      acc = idx_ready;
      tick();
      if (acc) begin
        n++;
        idx = 10'(20 + n);
      end
    end
    chk("bp_accepts", 64'(n), 64'd4);
    chk("bp_ready_low", 64'(idx_ready), 64'd0);
    idx_valid = 1'b0;
    vec_ready = 1'b1;
    repeat (8) tick();
    chk("bp_count", 64'(rxq.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < rxq.size())
        chk("bp_data", rxq[k][63:0], row(20 + k));
    rxq.delete();

    // out of bounds
    chk("oob_clear", 64'(err_oob), 64'd0);
    send(100, 1'b0);
    send(600, 1'b0);
    chk("oob_no_read", 64'(tbl_read_enable), 64'd0);
    send(101, 1'b0);
    repeat (5) tick();
    chk("oob_reads", 64'(oob_reads), 64'd0);
    chk("oob_count", 64'(rxq.size()), 64'd3);
    if (rxq.size() == 3) begin
      chk("oob_before", rxq[0][63:0], row(100));
      chk("oob_zero", rxq[1][63:0], 64'd0);
      chk("oob_after", rxq[2][63:0], row(101));
    end
    chk("oob_flag", 64'(err_oob), 64'd1);
    repeat (5) tick();
    chk("oob_sticky", 64'(err_oob), 64'd1);
    rxq.delete();

    // reset mid-stream: 2 queued, 2 in flight
    vec_ready = 1'b0;
    for (int i = 30; i < 34; i++)
      send(i, 1'b0);
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_vvalid", 64'(vec_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ready", 64'(idx_ready), 64'd0);
    chk("mrst_rden", 64'(tbl_read_enable), 64'd0);
    chk("mrst_tidx", 64'(tbl_index), 64'd0);
    chk("mrst_vvalid", 64'(vec_valid), 64'd0);
    chk("mrst_vdata", vec_data, 64'd0);
    chk("mrst_vlast", 64'(vec_last), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_err", 64'(err_oob), 64'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("mrel_ready", 64'(idx_ready), 64'd1);
    chk("mrel_vvalid", 64'(vec_valid), 64'd0);
    rxq.delete();
    vec_ready = 1'b1;
    send(9, 1'b0);
    repeat (4) tick();
    chk("mrel_count", 64'(rxq.size()), 64'd1);
    if (rxq.size() == 1)
      chk("mrel_data", rxq[0][63:0], row(9));

    // index 0
    vec_ready = 1'b0;
    send(0, 1'b0);
`ifdef EMB_FETCH_PAD_ZERO_EN
    chk("pad_no_read", 64'(tbl_read_enable), 64'd0);
`else
    chk("idx0_read", 64'(tbl_read_enable), 64'd1);
    chk("idx0_tidx", 64'(tbl_index), 64'd0);
`endif
    tick();
    chk("idx0_v1", 64'(vec_valid), 64'd0);
    tick();
    chk("idx0_v2", 64'(vec_valid), 64'd1);
`ifdef EMB_FETCH_PAD_ZERO_EN
    chk("pad_data", vec_data, 64'd0);
`else
    chk("idx0_data", vec_data, row(0));
`endif
    chk("idx0_err", 64'(err_oob), 64'd0);
    vec_ready = 1'b1;
    tick();
    chk("idx0_drained", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
